// File: rtl/rx_stream_merger_pkg.sv
// Shared types and helpers for rx_stream_merger: FSM state, round-robin pick
// function sized for the 16-channel maximum, and the channel index width helper.
package rx_merger_pkg;

  localparam int MAX_CH    = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_t;

  typedef struct packed {
    logic                 hit;
    logic [MAX_IDX_W-1:0] idx;
    logic [MAX_CH-1:0]    onehot;
  } rr_pick_t;

  // Channel index width, never below one bit so NUM_CH=1 still has a pointer.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Unused high mask bits are zero, so wrapping modulo 16 visits the same
  // channels in the same order as wrapping modulo NUM_CH.
  function automatic rr_pick_t next_rr(input logic [MAX_CH-1:0] mask,
                                       input logic [MAX_IDX_W-1:0] ptr);
    rr_pick_t             pick;
    logic [MAX_IDX_W-1:0] idx;
    pick = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      idx = ptr + MAX_IDX_W'(i);
      if (!pick.hit && mask[idx]) begin
        pick.hit         = 1'b1;
        pick.idx         = idx;
        pick.onehot[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rx_stream_merger_pick.sv
// rr_arbiter_pick: combinational round-robin search over the request mask,
// starting at ptr and wrapping, returning the first hit as one-hot and index.
module rr_arbiter_pick
  import rx_merger_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              hit,
  output logic [NUM_CH-1:0] onehot,
  output logic [IDX_W-1:0]  idx
);

  logic [MAX_CH-1:0]    req_pad;
  logic [MAX_IDX_W-1:0] ptr_pad;
  rr_pick_t             pick;
  logic                 unused_pick;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_CH-1:0]  = req;
    ptr_pad              = '0;
    ptr_pad[IDX_W-1:0]   = ptr;
    pick                 = next_rr(req_pad, ptr_pad);
  end

  assign hit         = pick.hit;
  assign onehot      = pick.onehot[NUM_CH-1:0];
  assign idx         = pick.idx[IDX_W-1:0];
  assign unused_pick = ^pick;

endmodule

// File: rtl/rx_stream_merger.sv
// Merges NUM_CH FWFT channel FIFOs into one registered FWFT stream with bounded
// round-robin bursts. Define RX_STREAM_MERGER_WORD_CNT_EN for per-channel word counters.
module rx_stream_merger
  import rx_merger_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          BUS_CLK,
  input  logic                          BUS_RST,
  input  logic [NUM_CH-1:0]             CH_ENABLE,
  input  logic [NUM_CH-1:0]             CH_FIFO_EMPTY,
  input  logic [NUM_CH*DWIDTH-1:0]      CH_FIFO_DATA,
  output logic [NUM_CH-1:0]             CH_FIFO_READ,
  input  logic                          FIFO_READ,
  output logic                          FIFO_EMPTY,
  output logic [DWIDTH-1:0]             FIFO_DATA,
  output logic [NUM_CH-1:0]             GRANT,
  output logic                          READ_ERROR,
  input  logic                          CNT_CLEAR,
  output logic [NUM_CH*CNT_WIDTH-1:0]   CH_WORD_CNT
);

  localparam int                    CH_IDX_W   = ch_idx_w(NUM_CH);
  localparam logic [7:0]            BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [CH_IDX_W-1:0]   LAST_CH    = CH_IDX_W'(NUM_CH - 1);

  state_t              state, state_next;
  logic [CH_IDX_W-1:0] rr_ptr, g_idx, pick_idx;
  logic [NUM_CH-1:0]   grant, pick_onehot, req;
  logic                pick_hit;
  logic [7:0]          burst_cnt;
  logic                out_valid, read_error;
  logic [DWIDTH-1:0]   out_data, g_data;
  logic                can_load, g_en, g_empty, pop, leave;

  assign req = CH_ENABLE & ~CH_FIFO_EMPTY;

  rr_arbiter_pick #(.NUM_CH(NUM_CH), .IDX_W(CH_IDX_W)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .hit    (pick_hit),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Valid/ready: a word moves downstream on FIFO_READ while FIFO_EMPTY=0; a word
  // moves in from channel g on CH_FIFO_READ[g], only when the output slot frees.
  always_comb begin
    can_load   = !out_valid || FIFO_READ;
    g_en       = CH_ENABLE[g_idx];
    g_empty    = CH_FIFO_EMPTY[g_idx];
    g_data     = CH_FIFO_DATA[int'(g_idx)*DWIDTH +: DWIDTH];
    pop        = 1'b0;
    leave      = 1'b0;
    state_next = state;
    case (state)
      ARB:  if (pick_hit) state_next = XFER;
      XFER: begin
        pop   = g_en && !g_empty && can_load;
        leave = !g_en || g_empty || (pop && burst_cnt == BURST_LAST);
        if (leave) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
    CH_FIFO_READ = pop ? grant : '0;
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) state <= ARB;
    else         state <= state_next;
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      grant     <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (state == ARB) begin
      if (pick_hit) begin
        grant <= pick_onehot;
        g_idx <= pick_idx;
      end
    end else if (leave) begin
      grant     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= (g_idx == LAST_CH) ? '0 : g_idx + 1'b1;
    end else if (pop) begin
      burst_cnt <= burst_cnt + 8'd1;
    end
  end

  // A pop wins over a downstream read so the slot reloads without a bubble.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      read_error <= 1'b0;
    end else begin
      if (pop) begin
        out_data  <= g_data;
        out_valid <= 1'b1;
      end else if (FIFO_READ) begin
        out_valid <= 1'b0;
      end
      if (FIFO_READ && !out_valid) read_error <= 1'b1;
    end
  end

  assign FIFO_EMPTY = !out_valid;
  assign FIFO_DATA  = out_data;
  assign GRANT      = grant;
  assign READ_ERROR = read_error;

`ifdef RX_STREAM_MERGER_WORD_CNT_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST)                              cnt <= '0;
      else if (CNT_CLEAR)                       cnt <= '0;
      else if (CH_FIFO_READ[k] && (cnt != '1))  cnt <= cnt + 1'b1;
    end
    assign CH_WORD_CNT[k*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = CNT_CLEAR;
  assign CH_WORD_CNT      = '0;
`endif

endmodule

// File: tb/tb_rx_stream_merger.sv
// Bench for rx_stream_merger: a 4-channel/MAX_BURST=2 instance and a 1-channel
// instance fed from modelled FWFT channel FIFOs, checked by a scoreboard monitor.
module tb_rx_stream_merger;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int CW  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [NCH-1:0]    ch_enable, ch_fifo_empty, ch_fifo_read, grant;
  logic [NCH*DW-1:0] ch_fifo_data;
  logic              fifo_read, fifo_empty, read_error, cnt_clear;
  logic [DW-1:0]     fifo_data;
  logic [NCH*CW-1:0] ch_word_cnt;

  logic              en1, empty1, read1, fifo_read1, fifo_empty1, read_error1, cnt_clear1;
  logic [0:0]        grant1;
  logic [DW-1:0]     data1, fifo_data1;
  logic [CW-1:0]     word_cnt1;

  rx_stream_merger #(.NUM_CH(NCH), .DWIDTH(DW), .MAX_BURST(2), .CNT_WIDTH(CW)) u_dut (
    .BUS_CLK(clk), .BUS_RST(rst),
    .CH_ENABLE(ch_enable), .CH_FIFO_EMPTY(ch_fifo_empty), .CH_FIFO_DATA(ch_fifo_data),
    .CH_FIFO_READ(ch_fifo_read), .FIFO_READ(fifo_read), .FIFO_EMPTY(fifo_empty),
    .FIFO_DATA(fifo_data), .GRANT(grant), .READ_ERROR(read_error),
    .CNT_CLEAR(cnt_clear), .CH_WORD_CNT(ch_word_cnt)
  );

  rx_stream_merger #(.NUM_CH(1), .DWIDTH(DW), .MAX_BURST(16), .CNT_WIDTH(CW)) u_one (
    .BUS_CLK(clk), .BUS_RST(rst),
    .CH_ENABLE(en1), .CH_FIFO_EMPTY(empty1), .CH_FIFO_DATA(data1),
    .CH_FIFO_READ(read1), .FIFO_READ(fifo_read1), .FIFO_EMPTY(fifo_empty1),
    .FIFO_DATA(fifo_data1), .GRANT(grant1), .READ_ERROR(read_error1),
    .CNT_CLEAR(cnt_clear1), .CH_WORD_CNT(word_cnt1)
  );

  // ---------------- channel FWFT FIFO models ----------------
  logic [DW-1:0] mem [NCH][256];
  int            wr [NCH] = '{default: 0};
  int            rd [NCH] = '{default: 0};
  logic [DW-1:0] mem1 [16];
  int            wr1 = 0;
  int            rd1 = 0;

  always_comb begin
    ch_fifo_empty = '0;
    ch_fifo_data  = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_fifo_empty[k]         = (rd[k] == wr[k]);
      ch_fifo_data[k*DW +: DW] = mem[k][rd[k]];
    end
    empty1 = (rd1 == wr1);
    data1  = mem1[rd1];
  end

  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++)
      if (ch_fifo_read[k]) rd[k] <= rd[k] + 1;
    if (read1) rd1 <= rd1 + 1;
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp1_q[$];
  int            xc_q[$];
  int            xc1_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && fifo_read && !fifo_empty) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL stray_word: got %0h expected none", fifo_data);
      end else chk("out_word", fifo_data, exp_q.pop_front());
      xc_q.push_back(cyc);
    end
    if (!rst && fifo_read1 && !fifo_empty1) begin
      if (exp1_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL stray_word1: got %0h expected none", fifo_data1);
      end else chk("out_word1", fifo_data1, exp1_q.pop_front());
      xc1_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [DW-1:0] wd(input int k, input int i);
    return 32'hC0DE_0000 | DW'(k << 8) | DW'(i);
  endfunction

  task automatic push(input int k, input logic [DW-1:0] w, input bit expect_it);
    mem[k][wr[k]] = w;
    wr[k]++;
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic push1(input logic [DW-1:0] w);
    mem1[wr1] = w;
    wr1++;
    exp1_q.push_back(w);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && t < 300) begin
      step();
      t++;
    end
    chk(name, 128'(exp_q.size() + exp1_q.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int t0;
  initial begin
    rst = 1'b1; ch_enable = '1; fifo_read = 1'b0; cnt_clear = 1'b0;
    en1 = 1'b1; fifo_read1 = 1'b0; cnt_clear1 = 1'b0;
    step(2);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_data", fifo_data, '0);
    chk("rst_grant", grant, '0);
    chk("rst_rderr", read_error, 1'b0);
    chk("rst_chread", ch_fifo_read, '0);
    chk("rst_cnt", ch_word_cnt, '0);
    chk("rst_empty1", fifo_empty1, 1'b1);
    rst = 1'b0;
    step();

    // single channel pass-through
    fifo_read1 = 1'b1;
    t0 = cyc;
    push1(32'hA1); push1(32'hA2); push1(32'hA3);
    drain("single_drain");
    chk("single_cnt", 128'(xc1_q.size()), 128'd3);
    if (xc1_q.size() == 3) begin
      chk("single_latency", 128'(xc1_q[0] - t0), 128'd2);
      chk("single_gap1", 128'(xc1_q[1] - xc1_q[0]), 128'd1);
      chk("single_gap2", 128'(xc1_q[2] - xc1_q[1]), 128'd1);
    end
    step(2);
    chk("single_empty_after", fifo_empty1, 1'b1);
    chk("single_grant_after", grant1, 1'b0);

    // fairness: bursts of two, one bubble between grants
    xc_q.delete();
    fifo_read = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < NCH; k++) push(k, wd(k, i), 1'b0);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NCH; k++)
        for (int j = 0; j < 2; j++) exp_q.push_back(wd(k, p*2 + j));
    drain("fair_drain");
    chk("fair_cnt", 128'(xc_q.size()), 128'd16);
    if (xc_q.size() == 16) begin
      chk("fair_latency", 128'(xc_q[0] - t0), 128'd2);
      for (int i = 1; i < 16; i++)
        chk("fair_gap", 128'(xc_q[i] - xc_q[i-1]), (i % 2 == 1) ? 128'd1 : 128'd2);
    end

    // backpressure mid-burst
    fifo_read = 1'b0;
    xc_q.delete();
    for (int i = 0; i < 4; i++) push(0, wd(0, 16 + i), 1'b1);
    step(2);
    chk("bp_grant", grant, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      chk("bp_no_pop", ch_fifo_read, '0);
      chk("bp_data_hold", fifo_data, wd(0, 16));
      chk("bp_not_empty", fifo_empty, 1'b0);
      step();
    end
    fifo_read = 1'b1;
    drain("bp_drain");
    if (xc_q.size() >= 2) chk("bp_resume_gap", 128'(xc_q[1] - xc_q[0]), 128'd1);
    else chk("bp_resume_cnt", 128'(xc_q.size()), 128'd2);

    // enable mask during ch1 burst
    fifo_read = 1'b0;
    for (int i = 0; i < 4; i++) push(1, wd(1, 16 + i), 1'b0);
    push(2, wd(2, 16), 1'b0);
    push(2, wd(2, 17), 1'b0);
    exp_q.push_back(wd(1, 16));
    exp_q.push_back(wd(2, 16));
    exp_q.push_back(wd(2, 17));
    step(2);
    chk("en_grant_ch1", grant, 4'b0010);
    ch_enable[1] = 1'b0;
    step();
    chk("en_leave_arb", grant, 4'b0000);
    chk("en_no_pop", ch_fifo_read, '0);
    step();
    chk("en_next_ch2", grant, 4'b0100);
    chk("en_pending_data", fifo_data, wd(1, 16));
    chk("en_pending_valid", fifo_empty, 1'b0);
    fifo_read = 1'b1;
    drain("en_drain");
    ch_enable[1] = 1'b1;
    for (int i = 1; i < 4; i++) exp_q.push_back(wd(1, 16 + i));
    drain("en_reenable_drain");

    // sticky read error, async reset mid-burst
    fifo_read = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
    chk("err_clear", read_error, 1'b0);
    fifo_read = 1'b1; step(); fifo_read = 1'b0;
    chk("err_set", read_error, 1'b1);
    step(3);
    chk("err_sticky", read_error, 1'b1);
    push(3, wd(3, 16), 1'b0);
    step(2);
    chk("pre_rst_grant", grant, 4'b1000);
    chk("pre_rst_valid", fifo_empty, 1'b0);
    #4 rst = 1'b1;
    #1;
    chk("arst_rderr", read_error, 1'b0);
    chk("arst_empty", fifo_empty, 1'b1);
    chk("arst_grant", grant, '0);
    chk("arst_data", fifo_data, '0);
    step();
    rst = 1'b0;
    step();

    // word counters
    fifo_read = 1'b1;
    for (int i = 0; i < 10; i++) push(2, wd(2, 32 + i), 1'b1);
    drain("cnt_drain");
`ifdef RX_STREAM_MERGER_WORD_CNT_EN
    chk("cnt_ch2", ch_word_cnt[2*CW +: CW], 128'd10);
`else
    chk("cnt_ch2", ch_word_cnt[2*CW +: CW], 128'd0);
`endif
    chk("cnt_ch0", ch_word_cnt[0 +: CW], 128'd0);
    chk("cnt_ch1", ch_word_cnt[CW +: CW], 128'd0);
    chk("cnt_ch3", ch_word_cnt[3*CW +: CW], 128'd0);
    fifo_read = 1'b0;
    push(2, wd(2, 48), 1'b1);
    push(2, wd(2, 49), 1'b1);
    step();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("cnt_clear_pop", ch_word_cnt[2*CW +: CW], 128'd0);
    fifo_read = 1'b1;
    drain("cnt_clear_drain");
`ifdef RX_STREAM_MERGER_WORD_CNT_EN
    chk("cnt_after_clear", ch_word_cnt[2*CW +: CW], 128'd1);
`else
    chk("cnt_after_clear", ch_word_cnt[2*CW +: CW], 128'd0);
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
